// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared constants and helpers for the SID mixer
package sid_pkg;
   localparam logic [4:0] SID_VOL_ADDR   = 5'h18;
   localparam int         SID_NUM_VOICES = 3;
   localparam int         SID_VOICE_W    = 12;
   localparam int         SID_ENV_W      = 8;
   localparam int         SID_OUT_W      = 16;
   localparam int         SID_HEADROOM   = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/sid_mixer_mac.sv
// rtl/sid_mixer_mac.sv - registered signed x unsigned multiply-accumulate
module sid_mixer_mac #(
   parameter int A_W   = 12,
   parameter int B_W   = 8,
   parameter int ACC_W = 23
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a,
   input  logic        [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc
);
   localparam int P_W = A_W + B_W;

   // Both operands widened to the product width so the multiply stays signed.
   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;
   logic signed [P_W-1:0] prod;

   assign a_ext = {{B_W{a[A_W-1]}}, a};
   assign b_ext = {{A_W{1'b0}}, b};
   assign prod  = a_ext * b_ext;

   always_ff @(posedge clk) begin
      if (rst || clr)
         acc <= '0;
      else if (en)
         acc <= acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
   end
endmodule

// File: rtl/sid_mixer.sv
// rtl/sid_mixer.sv - time-multiplexed voice mixer with master volume, mute and saturation
module sid_mixer
   import sid_pkg::*;
#(
   parameter int         NUM_VOICES = SID_NUM_VOICES,
   parameter int         VOICE_W    = SID_VOICE_W,
   parameter int         ENV_W      = SID_ENV_W,
   parameter int         OUT_W      = SID_OUT_W,
   parameter int         HEADROOM   = SID_HEADROOM,
   parameter logic [4:0] VOL_ADDR   = SID_VOL_ADDR
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          CLKen,
   input  logic                          WR,
   input  logic [4:0]                    ADDR,
   input  logic [7:0]                    DATA,
   input  logic [NUM_VOICES*VOICE_W-1:0] VOICES,
   input  logic [NUM_VOICES*ENV_W-1:0]   ENVS,
   output logic signed [OUT_W-1:0]       OUTPUT,
   output logic                          VALID,
   output logic                          BUSY,
   output logic                          OVERRUN
);
   localparam int IDX_W = (NUM_VOICES > 1) ? clog2(NUM_VOICES) : 1;
   localparam int ACC_W = VOICE_W + ENV_W + clog2(NUM_VOICES) + 1;
   localparam int SW    = ACC_W + 5;
   localparam int SHIFT = VOICE_W + ENV_W - OUT_W + HEADROOM;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic signed [SW-1:0] SAT_HI = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_LO = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_MAC   = 2'd1;
   localparam logic [1:0] ST_SCALE = 2'd2;

   logic [1:0]                    state;
   logic [IDX_W-1:0]              idx;
   logic [NUM_VOICES*VOICE_W-1:0] voices_q;
   logic [NUM_VOICES*ENV_W-1:0]   envs_q;
   logic [3:0]                    vol_reg, vol_snap;
   logic                          mute_reg, mute_snap;
   logic [VOICE_W-1:0]            v_sel;
   logic [ENV_W-1:0]              e_sel;
   logic signed [VOICE_W-1:0]     mac_a;
   logic signed [ACC_W-1:0]       acc;
   logic signed [SW-1:0]          acc_ext, vol_ext, scaled, shifted;
   logic signed [OUT_W-1:0]       sat_out;
   logic                          unused_data;
   int                            vsel, esel;

   assign unused_data = ^DATA[6:4];
   assign BUSY        = (state != ST_IDLE);

   always_comb begin
      vsel  = int'(idx) * VOICE_W;
      esel  = int'(idx) * ENV_W;
      v_sel = voices_q[vsel +: VOICE_W];
      e_sel = envs_q[esel +: ENV_W];
      mac_a = {~v_sel[VOICE_W-1], v_sel[VOICE_W-2:0]};
      if (mute_snap && idx == LAST_IDX)
         mac_a = '0;
   end

   sid_mixer_mac #(.A_W(VOICE_W), .B_W(ENV_W), .ACC_W(ACC_W)) u_mac (
      .clk (CLK),
      .rst (RST),
      .clr (state == ST_IDLE && CLKen),
      .en  (state == ST_MAC),
      .a   (mac_a),
      .b   (e_sel),
      .acc (acc)
   );

   // Headroom shift and the /16 volume step are folded into one shift so truncation happens once.
   always_comb begin
      acc_ext = {{5{acc[ACC_W-1]}}, acc};
      vol_ext = {{(SW-4){1'b0}}, vol_snap};
      scaled  = acc_ext * vol_ext;
      shifted = scaled >>> (SHIFT + 4);
      if (shifted > SAT_HI)
         sat_out = SAT_HI[OUT_W-1:0];
      else if (shifted < SAT_LO)
         sat_out = SAT_LO[OUT_W-1:0];
      else
         sat_out = shifted[OUT_W-1:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         idx       <= '0;
         voices_q  <= '0;
         envs_q    <= '0;
         vol_reg   <= '0;
         mute_reg  <= 1'b0;
         vol_snap  <= '0;
         mute_snap <= 1'b0;
         OUTPUT    <= '0;
         VALID     <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         VALID   <= 1'b0;
         OVERRUN <= CLKen && (state != ST_IDLE);
         if (WR && ADDR == VOL_ADDR) begin
            vol_reg  <= DATA[3:0];
            mute_reg <= DATA[7];
         end
         case (state)
            ST_IDLE: begin
               if (CLKen) begin
                  voices_q  <= VOICES;
                  envs_q    <= ENVS;
                  vol_snap  <= vol_reg;
                  mute_snap <= mute_reg;
                  idx       <= '0;
                  state     <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (idx == LAST_IDX)
                  state <= ST_SCALE;
               else
                  idx <= idx + IDX_W'(1);
            end
            ST_SCALE: begin
               OUTPUT <= sat_out;
               VALID  <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sid_mixer.sv
// tb/tb_sid_mixer.sv - directed self-checking bench for sid_mixer
module tb_sid_mixer;
   logic               CLK = 1'b0;
   logic               RST, CLKen, WR;
   logic [4:0]         ADDR;
   logic [7:0]         DATA;
   logic [35:0]        VOICES;
   logic [23:0]        ENVS;
   logic signed [15:0] out_a, out_b;
   logic               valid_a, busy_a, overrun_a;
   logic               valid_b, busy_b, overrun_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   sid_mixer dut (
      .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
      .VOICES(VOICES), .ENVS(ENVS), .OUTPUT(out_a), .VALID(valid_a),
      .BUSY(busy_a), .OVERRUN(overrun_a)
   );

   sid_mixer #(.HEADROOM(0)) dut_h0 (
      .CLK(CLK), .RST(RST), .CLKen(CLKen), .WR(WR), .ADDR(ADDR), .DATA(DATA),
      .VOICES(VOICES), .ENVS(ENVS), .OUTPUT(out_b), .VALID(valid_b),
      .BUSY(busy_b), .OVERRUN(overrun_b)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
      WR = 1'b1; ADDR = a; DATA = d;
      tick();
      WR = 1'b0;
   endtask

   task automatic run_mix(output int lat, output int val);
      CLKen = 1'b1;
      tick();
      CLKen = 1'b0;
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (valid_a) begin
            lat = i;
            break;
         end
      end
      val = int'(out_a);
   endtask

   task automatic test_reset();
      RST = 1'b1; CLKen = 1'b0; WR = 1'b0; ADDR = '0; DATA = '0;
      VOICES = '0; ENVS = '0;
      repeat (3) tick();
      n_checks++;
      if (out_a !== 16'sd0) begin n_fail++; $display("FAIL reset_output: got %0d expected 0", out_a); end
      n_checks++;
      if ({valid_a, busy_a, overrun_a} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 000", {valid_a, busy_a, overrun_a});
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat, val;
      VOICES = {12'h800, 12'h800, 12'hFFF};
      ENVS   = {8'hFF, 8'hFF, 8'hFF};
      write_reg(5'h18, 8'h7F);  // bits 6:4 must be ignored
      run_mix(lat, val);
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", lat); end
      n_checks++;
      if (val !== 7646) begin n_fail++; $display("FAIL basic_output: got %0d expected 7646", val); end
      tick();
      n_checks++;
      if ({valid_a, busy_a} !== 2'b00) begin
         n_fail++; $display("FAIL basic_after: got %b expected 00", {valid_a, busy_a});
      end
   endtask

   task automatic test_full_scale();
      int lat, val;
      VOICES = '0;
      ENVS   = {8'hFF, 8'hFF, 8'hFF};
      run_mix(lat, val);
      n_checks++;
      if (val !== -22950) begin n_fail++; $display("FAIL full_scale: got %0d expected -22950", val); end
      n_checks++;
      if (out_b !== -16'sd32768) begin n_fail++; $display("FAIL saturate_h0: got %0d expected -32768", out_b); end
   endtask

   task automatic test_mute();
      int lat, val;
      VOICES = {12'hFFF, 12'h800, 12'h800};
      ENVS   = {8'hFF, 8'hFF, 8'hFF};
      write_reg(5'h18, 8'h8F);
      run_mix(lat, val);
      n_checks++;
      if (val !== 0) begin n_fail++; $display("FAIL muted: got %0d expected 0", val); end
      write_reg(5'h18, 8'h0F);
      write_reg(5'h17, 8'h80);  // wrong address must not mute
      run_mix(lat, val);
      n_checks++;
      if (val !== 7646) begin n_fail++; $display("FAIL unmuted: got %0d expected 7646", val); end
   endtask

   task automatic test_volume();
      int lat, val;
      bit seen;
      VOICES = {12'h800, 12'h800, 12'hFFF};
      ENVS   = {8'hFF, 8'hFF, 8'hFF};
      write_reg(5'h18, 8'h00);
      run_mix(lat, val);
      n_checks++;
      if (lat !== 4 || val !== 0) begin
         n_fail++; $display("FAIL vol_zero: got lat %0d out %0d expected lat 4 out 0", lat, val);
      end
      CLKen = 1'b1;
      tick();
      CLKen = 1'b0;
      write_reg(5'h18, 8'h0F);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (valid_a) seen = 1'b1;
         else tick();
      end
      n_checks++;
      if (!seen || out_a !== 16'sd0) begin
         n_fail++; $display("FAIL vol_mid_write: got valid %0d out %0d expected valid 1 out 0", seen, out_a);
      end
      tick();
      run_mix(lat, val);
      n_checks++;
      if (val !== 7646) begin n_fail++; $display("FAIL vol_next: got %0d expected 7646", val); end
   endtask

   task automatic test_back_to_back();
      int lat, extra;
      CLKen = 1'b1; tick();      // edge T
      CLKen = 1'b0; tick();      // T+1
      CLKen = 1'b1; tick();      // T+2, dropped
      n_checks++;
      if ({overrun_a, busy_a} !== 2'b11) begin
         n_fail++; $display("FAIL overrun_pulse: got %b expected 11", {overrun_a, busy_a});
      end
      CLKen = 1'b0; tick();      // T+3
      n_checks++;
      if ({overrun_a, valid_a} !== 2'b00) begin
         n_fail++; $display("FAIL overrun_one_cycle: got %b expected 00", {overrun_a, valid_a});
      end
      tick();                    // T+4
      n_checks++;
      if (valid_a !== 1'b1 || out_a !== 16'sd7646) begin
         n_fail++; $display("FAIL first_valid: got valid %0d out %0d expected valid 1 out 7646", valid_a, out_a);
      end
      CLKen = 1'b1; tick();      // accepted on the VALID cycle
      CLKen = 1'b0;
      n_checks++;
      if ({overrun_a, busy_a} !== 2'b01) begin
         n_fail++; $display("FAIL accept_on_valid: got %b expected 01", {overrun_a, busy_a});
      end
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (valid_a) begin lat = i; break; end
      end
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL second_valid_latency: got %0d expected 4", lat); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_a) extra++;
      end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL no_queued_request: got %0d expected 0", extra); end
   endtask

   task automatic test_reset_mid_mix();
      int lat, val, seen;
      CLKen = 1'b1; tick();      // edge T
      CLKen = 1'b0; tick();      // T+1
      RST = 1'b1; tick();        // T+2
      RST = 1'b0;
      n_checks++;
      if (busy_a !== 1'b0 || out_a !== 16'sd0) begin
         n_fail++; $display("FAIL reset_abort: got busy %0d out %0d expected busy 0 out 0", busy_a, out_a);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_a) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL reset_no_valid: got %0d expected 0", seen); end
      run_mix(lat, val);
      n_checks++;
      if (lat !== 4 || val !== 0) begin
         n_fail++; $display("FAIL reset_vol_zero: got lat %0d out %0d expected lat 4 out 0", lat, val);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_scale();
      test_mute();
      test_volume();
      test_back_to_back();
      test_reset_mid_mix();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
